spram_banked_mem: RTL and testbench
===================================

// Module: spram_banked_mem
// PURPOSE
//  Parametrised SPRAM main-memory controller: N banks of 32-bit words (2x SB_SPRAM256KA per bank).
//  Sits between the CPU native memory bus (valid/ready, byte strobes) and the SPRAM primitives.
//  Adds a registered handshake and range checking.
//  Adds per-bank idle power-down via SLEEP, with automatic wake on access.
// PARAMETERS
//  NUM_BANKS    2   banks of 16K x 32b (64 KiB each); legal values 1, 2, 4
//  SLEEP_IDLE   256 idle cycles before a bank enters SLEEP; 0 = never sleep
//  WAKE_CYCLES  4   cycles a bank must be awake (SLEEP=0) before it is accessed; >=1
// PORTS
//  clk          in   1   clock
//  reset        in   1   synchronous, active-high reset
//  mem_valid    in   1   request valid; held by the master until mem_ready
//  mem_ready    out  1   one-cycle completion pulse
//  mem_addr     in   32  byte address; bits [1:0] ignored
//  mem_wdata    in   32  write data
//  mem_wstrb    in   4   byte write enables; 4'b0000 = read
//  mem_rdata    out  32  read data, valid when mem_ready=1
//  mem_err      out  1   with mem_ready: address out of range
//  bank_asleep  out  NUM_BANKS  per-bank SLEEP status
// BEHAVIOUR
//  Address decode: word = mem_addr[15:2]; bank = mem_addr[15+BW:16], BW=clog2(NUM_BANKS).
//  Out of range: any mem_addr[31:16+BW] bit set.
//  Reset values: mem_ready=0, mem_rdata=0, mem_err=0, bank_asleep=0 (all awake).
//  On reset: idle counters=0, FSM=IDLE, SPRAM CHIPSELECT/WREN=0.
//  Reset mid-transaction aborts it: no mem_ready is issued and no write occurs after reset.
//  FSM states and transitions:
//   IDLE : if mem_valid && !mem_ready, latch addr/wdata/wstrb. Then:
//          out of range -> RESP; target asleep -> WAKE; else -> ACC.
//          mem_valid in the cycle mem_ready=1 is ignored.
//   WAKE : drop target SLEEP; count WAKE_CYCLES, then -> ACC.
//   ACC  : drive CHIPSELECT of the target bank only; WREN=|wstrb.
//          MASKWREN nibbles per byte: lo SPRAM {s1,s1,s0,s0}, hi SPRAM {s3,s3,s2,s2}. Then -> RESP.
//   RESP : mem_ready=1 for exactly one cycle; then -> IDLE.
//          Read: mem_rdata=bank DATAOUT; write: mem_rdata unchanged.
//          Error: mem_rdata=0, mem_err=1, no SPRAM write.
//  Latency, valid sampled to mem_ready: awake bank 3 cycles; asleep bank 3+WAKE_CYCLES; error 2.
//  mem_rdata holds its value between responses; mem_err is 0 outside mem_ready.
//  Power (per bank): idle counter clears when the bank is targeted (WAKE/ACC), else increments.
//   Counter saturates at SLEEP_IDLE. At SLEEP_IDLE, SLEEP=1 and bank_asleep=1.
//   SLEEP_IDLE=0 disables power-down.
//   A bank never sleeps while in WAKE/ACC for it; STANDBY=0, POWEROFF=1 always.
//  mem_wstrb partial masks write only the enabled bytes; other bytes keep their prior contents.
//  mem_addr/mem_wdata changes while a request is in flight have no effect (request is latched).
// TESTING
//  T1 write 0xDEADBEEF @0x0000_0010 wstrb=F, read back -> mem_rdata=0xDEADBEEF, latency 3, mem_err=0.
//  T2 wstrb=4'b0100 data 0x00AA0000 over T1 word -> read 0xDEAABEEF.
//  T3 NUM_BANKS=2: write 0x11111111 @0x0, 0x22222222 @0x10000 -> read back distinct values; bank1 CS only.
//  T4 read @0x0002_0000 (NUM_BANKS=2) -> ready after 2 cycles, mem_err=1, rdata=0; memory unchanged.
//  T5 SLEEP_IDLE=8, WAKE_CYCLES=4: 8 idle cycles -> bank_asleep=2'b11.
//     Then a read of bank0 -> latency 7, data intact, bank_asleep=2'b10.
//  T6 reset asserted in the cycle after write sampled -> no mem_ready, target word unchanged, outputs at reset values.

Source files
------------

// File: rtl/spram_banked_mem_if.sv
// CPU native memory bus: valid/ready handshake with byte strobes and an error flag.
interface spram_banked_mem_if;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_err;

    modport master (
        output mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata, mem_err
    );

    modport slave (
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata, mem_err
    );
endinterface

// File: rtl/spram_banked_mem.sv
// Banked SPRAM main memory: NUM_BANKS x (16K x 32b), each bank built from a lo/hi
// pair of 16-bit SPRAM halves. Registered handshake, range check and per-bank idle
// sleep with automatic wake on access.

// One bank: two 16K x 16 SPRAM halves, idle counter and SLEEP control.
// STANDBY is tied low and POWEROFF high on the real primitive, so only SLEEP is modelled.
module spram_banked_mem_bank #(
    parameter int SLEEP_IDLE = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        targeted,
    input  logic        cs,
    input  logic        wren,
    input  logic [13:0] addr,
    input  logic [31:0] din,
    input  logic [3:0]  wstrb,
    output logic [31:0] dout,
    output logic        asleep
);
    localparam int CW = (SLEEP_IDLE > 0) ? $clog2(SLEEP_IDLE + 1) : 1;

    logic [CW-1:0]   idle_cnt;
    logic            sleep;
    logic [1:0][3:0] maskwren;

    // Each byte strobe enables the two nibbles of its byte.
    assign maskwren[0] = {wstrb[1], wstrb[1], wstrb[0], wstrb[0]};
    assign maskwren[1] = {wstrb[3], wstrb[3], wstrb[2], wstrb[2]};

    // A bank that the FSM is waking or accessing is never put to sleep.
    assign sleep  = (SLEEP_IDLE != 0) && (idle_cnt == CW'(SLEEP_IDLE)) && !targeted;
    assign asleep = sleep;

    // Idle counter: cleared while targeted, otherwise counts up and saturates.
    always_ff @(posedge clk) begin
        if (reset)
            idle_cnt <= '0;
        else if (targeted)
            idle_cnt <= '0;
        else if (idle_cnt != CW'(SLEEP_IDLE))
            idle_cnt <= idle_cnt + 1'b1;
    end

    for (genvar h = 0; h < 2; h++) begin : g_half
        logic [15:0] ram [16384];
        logic [15:0] q;

        // SPRAM half: nibble-masked write, registered read; output holds when idle.
        always_ff @(posedge clk) begin
            if (cs && !sleep) begin
                if (wren) begin
                    for (int n = 0; n < 4; n++)
                        if (maskwren[h][n])
                            ram[addr][4*n +: 4] <= din[16*h + 4*n +: 4];
                end else begin
                    q <= ram[addr];
                end
            end
        end

        assign dout[16*h +: 16] = q;
    end
endmodule

module spram_banked_mem #(
    parameter int NUM_BANKS   = 2,
    parameter int SLEEP_IDLE  = 256,
    parameter int WAKE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    spram_banked_mem_if.slave    bus,
    output logic [NUM_BANKS-1:0] bank_asleep
);
    localparam int BW  = $clog2(NUM_BANKS);
    localparam int BIW = (BW > 0) ? BW : 1;
    localparam int WCW = $clog2(WAKE_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, WAKE, ACC, RESP} state_t;

    state_t          state, state_nx;
    logic [BIW-1:0]  in_bank;
    logic            in_oor;
    logic [BIW-1:0]  req_bank;
    logic [13:0]     req_word;
    logic [31:0]     req_wdata;
    logic [3:0]      req_wstrb;
    logic            req_err;
    logic [WCW-1:0]  wake_cnt;
    logic            ready_q;
    logic            err_q;
    logic [31:0]     rdata_q;
    logic            take;

    logic [NUM_BANKS-1:0]       bank_cs;
    logic [NUM_BANKS-1:0]       bank_tgt;
    logic [NUM_BANKS-1:0][31:0] bank_dout;

    logic unused_addr_lsb;
    assign unused_addr_lsb = &{1'b0, bus.mem_addr[1:0]};

    // Request decode straight from the bus; only used in the cycle it is latched.
    if (BW > 0) begin : g_bank_dec
        assign in_bank = bus.mem_addr[15+BW:16];
    end else begin : g_one_bank
        assign in_bank = '0;
    end
    assign in_oor = |bus.mem_addr[31:16+BW];

    // Valid in the cycle mem_ready is high belongs to the finished request.
    assign take = (state == IDLE) && bus.mem_valid && !ready_q;

    assign bus.mem_ready = ready_q;
    assign bus.mem_err   = err_q;
    assign bus.mem_rdata = rdata_q;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        assign bank_tgt[b] = ((state == WAKE) || (state == ACC)) && (req_bank == BIW'(b));
        // Chip select is forced low during reset so an aborted write never lands.
        assign bank_cs[b]  = (state == ACC) && (req_bank == BIW'(b)) && !reset;

        spram_banked_mem_bank #(.SLEEP_IDLE(SLEEP_IDLE)) u_bank (
            .clk      (clk),
            .reset    (reset),
            .targeted (bank_tgt[b]),
            .cs       (bank_cs[b]),
            .wren     (|req_wstrb),
            .addr     (req_word),
            .din      (req_wdata),
            .wstrb    (req_wstrb),
            .dout     (bank_dout[b]),
            .asleep   (bank_asleep[b])
        );
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (take) begin
                if (in_oor)                    state_nx = RESP;
                else if (bank_asleep[in_bank]) state_nx = WAKE;
                else                           state_nx = ACC;
            end
            WAKE: if (wake_cnt == WCW'(WAKE_CYCLES - 1)) state_nx = ACC;
            ACC:  state_nx = RESP;
            RESP: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register, request latch, wake timer and registered response.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            req_bank  <= '0;
            req_word  <= '0;
            req_wdata <= '0;
            req_wstrb <= '0;
            req_err   <= 1'b0;
            wake_cnt  <= '0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state <= state_nx;
            if (take) begin
                req_bank  <= in_bank;
                req_word  <= bus.mem_addr[15:2];
                req_wdata <= bus.mem_wdata;
                req_wstrb <= bus.mem_wstrb;
                req_err   <= in_oor;
            end
            wake_cnt <= (state == WAKE) ? wake_cnt + 1'b1 : '0;
            ready_q  <= (state == RESP);
            err_q    <= (state == RESP) && req_err;
            if (state == RESP) begin
                if (req_err)
                    rdata_q <= '0;
                else if (req_wstrb == 4'b0000)
                    rdata_q <= bank_dout[req_bank];
            end
        end
    end
endmodule

// File: tb/tb_spram_banked_mem.sv
// Bench for spram_banked_mem: cycle-level reference model plus directed and random requests.
module tb_spram_banked_mem;
    localparam int NB = 2;
    localparam int SI = 8;
    localparam int WC = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NB-1:0] bank_asleep;

    spram_banked_mem_if bus();

    spram_banked_mem #(.NUM_BANKS(NB), .SLEEP_IDLE(SI), .WAKE_CYCLES(WC)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .bank_asleep (bank_asleep)
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    bit chk_en = 0;
    bit mon_on = 0;
    logic [NB-1:0] cs_seen = '0;

    // Reference model state: a request timeline derived from the latency rules.
    int          e = 0;
    bit          busy = 0;
    int          s = 0, len = 0;
    bit          m_err = 0;
    int          m_bank = 0, m_word = 0;
    logic [31:0] m_wdata = '0;
    logic [3:0]  m_wstrb = '0;
    int          cnt [NB];
    bit          exp_ready = 0, exp_err = 0;
    logic [31:0] exp_rdata = '0;
    logic [31:0] mdl_mem [int];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
        end
    endtask

    task automatic model_step();
        int oc [NB];
        bit ob, orr, asl;
        int key;
        logic [31:0] w;
        ob = busy; orr = exp_ready; oc = cnt;
        e++;
        if (reset) begin
            busy = 0; exp_ready = 0; exp_err = 0; exp_rdata = '0;
            for (int b = 0; b < NB; b++) cnt[b] = 0;
            return;
        end
        for (int b = 0; b < NB; b++) begin
            if (ob && !m_err && b == m_bank && e >= s + 1 && e <= s + len) cnt[b] = 0;
            else if (cnt[b] < SI) cnt[b]++;
        end
        exp_ready = 0; exp_err = 0;
        if (ob && e == s + len + 1) begin
            busy = 0; exp_ready = 1;
            key = m_bank * 16384 + m_word;
            if (m_err) begin
                exp_rdata = '0; exp_err = 1;
            end else if (m_wstrb == 4'b0000) begin
                exp_rdata = mdl_mem.exists(key) ? mdl_mem[key] : 32'h0;
            end else begin
                w = mdl_mem.exists(key) ? mdl_mem[key] : 32'h0;
                for (int i = 0; i < 4; i++)
                    if (m_wstrb[i]) w[8*i +: 8] = m_wdata[8*i +: 8];
                mdl_mem[key] = w;
            end
        end
        if (!ob && !orr && bus.mem_valid) begin
            s       = e;
            m_err   = |bus.mem_addr[31:17];
            m_bank  = int'(bus.mem_addr[16]);
            m_word  = int'(bus.mem_addr[15:2]);
            m_wdata = bus.mem_wdata;
            m_wstrb = bus.mem_wstrb;
            asl     = (SI != 0) && (oc[m_bank] == SI);
            len     = m_err ? 0 : (asl ? WC + 1 : 1);
            busy    = 1;
        end
    endtask

    function automatic logic [NB-1:0] exp_asleep();
        logic [NB-1:0] r;
        for (int b = 0; b < NB; b++)
            r[b] = (SI != 0) && (cnt[b] == SI) &&
                   !(busy && !m_err && b == m_bank && e >= s && e <= s + len - 1);
        return r;
    endfunction

    initial begin
        for (int b = 0; b < NB; b++) cnt[b] = 0;
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Per-cycle comparison of every output against the model.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("ready", 32'(bus.mem_ready), 32'(exp_ready));
            chk("err", 32'(bus.mem_err), 32'(exp_err));
            chk("rdata", bus.mem_rdata, exp_rdata);
            chk("asleep", 32'(bank_asleep), 32'(exp_asleep()));
        end
    end

    initial forever begin
        @(negedge clk);
        if (mon_on) cs_seen = cs_seen | dut.bank_cs;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Issue one request from a negedge; returns at the negedge where mem_ready is seen.
    task automatic do_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                          output logic [31:0] rd, output bit er, output int lat);
        bit skip;
        skip = bus.mem_ready;
        bus.mem_valid = 1'b1; bus.mem_addr = a; bus.mem_wdata = d; bus.mem_wstrb = st;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (lat == (skip ? 2 : 1)) begin
                bus.mem_addr = $urandom; bus.mem_wdata = $urandom; bus.mem_wstrb = 4'($urandom);
            end
        end while (!bus.mem_ready && lat < 60);
        if (!bus.mem_ready) chk("timeout", 32'(lat), 32'd0);
        rd = bus.mem_rdata; er = bus.mem_err;
        bus.mem_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] rd, a;
        logic [3:0]  st;
        bit          er;
        int          lat, g;
        int          pool [6] = '{0, 1, 4, 5, 256, 16383};

        bus.mem_valid = 1'b0; bus.mem_addr = '0; bus.mem_wdata = '0; bus.mem_wstrb = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(bus.mem_ready), 32'd0);
        chk("rst_rdata", bus.mem_rdata, 32'd0);
        chk("rst_err", 32'(bus.mem_err), 32'd0);
        chk("rst_asleep", 32'(bank_asleep), 32'd0);
        reset = 1'b0; chk_en = 1;

        // Sleep threshold: 7 idle cycles awake, 8th puts both banks to sleep.
        idle(7); chk("sleep_7", 32'(bank_asleep), 32'd0);
        idle(1); chk("sleep_8", 32'(bank_asleep), 32'h3);

        // T1: write into a sleeping bank, then read back from the now-awake bank.
        do_req(32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
        chk("t1_wr_lat", 32'(lat), 32'd7);
        idle(1);
        do_req(32'h10, 32'h0, 4'h0, rd, er, lat);
        chk("t1_lat", 32'(lat), 32'd3);
        chk("t1_rd", rd, 32'hDEADBEEF);
        chk("t1_err", 32'(er), 32'd0);

        // T2: single-byte write merges into the existing word.
        idle(1);
        do_req(32'h10, 32'h00AA0000, 4'b0100, rd, er, lat);
        idle(1);
        do_req(32'h10, 32'h0, 4'h0, rd, er, lat);
        chk("t2_rd", rd, 32'hDEAABEEF);

        // T3: same word offset in two banks; bank1 write selects bank1 only.
        idle(1);
        do_req(32'h0, 32'h11111111, 4'hF, rd, er, lat);
        idle(1);
        cs_seen = '0; mon_on = 1;
        do_req(32'h10000, 32'h22222222, 4'hF, rd, er, lat);
        mon_on = 0;
        chk("t3_cs", 32'(cs_seen), 32'h2);
        idle(1);
        do_req(32'h0, 32'h0, 4'h0, rd, er, lat);
        chk("t3_rd0", rd, 32'h11111111);
        idle(1);
        do_req(32'h10000, 32'h0, 4'h0, rd, er, lat);
        chk("t3_rd1", rd, 32'h22222222);

        // T4: out-of-range read and write; aliasing word must stay untouched.
        idle(1);
        do_req(32'h20000, 32'h0, 4'h0, rd, er, lat);
        chk("t4_lat", 32'(lat), 32'd2);
        chk("t4_err", 32'(er), 32'd1);
        chk("t4_rd", rd, 32'h0);
        idle(1);
        do_req(32'h20010, 32'hFFFFFFFF, 4'hF, rd, er, lat);
        chk("t4_wr_err", 32'(er), 32'd1);
        idle(1);
        do_req(32'h0, 32'h0, 4'h0, rd, er, lat);
        chk("t4_rd0", rd, 32'h11111111);

        // T5: both banks asleep, read bank0 wakes it only.
        idle(12);
        chk("t5_asleep", 32'(bank_asleep), 32'h3);
        do_req(32'h10, 32'h0, 4'h0, rd, er, lat);
        chk("t5_lat", 32'(lat), 32'd7);
        chk("t5_rd", rd, 32'hDEAABEEF);
        chk("t5_asleep2", 32'(bank_asleep), 32'h2);

        // T6: reset the cycle after a write is sampled.
        idle(1);
        bus.mem_valid = 1'b1; bus.mem_addr = 32'h10; bus.mem_wdata = 32'h12345678; bus.mem_wstrb = 4'hF;
        @(posedge clk); @(negedge clk);
        reset = 1'b1; bus.mem_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("t6_ready", 32'(bus.mem_ready), 32'd0);
        chk("t6_rdata", bus.mem_rdata, 32'd0);
        chk("t6_err", 32'(bus.mem_err), 32'd0);
        chk("t6_asleep", 32'(bank_asleep), 32'd0);
        idle(2);
        reset = 1'b0;
        idle(1);
        do_req(32'h10, 32'h0, 4'h0, rd, er, lat);
        chk("t6_lat", 32'(lat), 32'd3);
        chk("t6_rd", rd, 32'hDEAABEEF);

        // Random phase: prefill a small pool, then mixed traffic with random gaps.
        for (int b = 0; b < NB; b++)
            for (int k = 0; k < 6; k++) begin
                idle(1);
                do_req(32'(b) << 16 | 32'(pool[k]) << 2, $urandom, 4'hF, rd, er, lat);
            end
        for (int n = 0; n < 200; n++) begin
            g = ($urandom_range(0, 9) == 0) ? 10 : $urandom_range(0, 3);
            idle(g);
            a  = 32'($urandom_range(0, NB - 1)) << 16 | 32'(pool[$urandom_range(0, 5)]) << 2
                 | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) a = a | (32'd1 << $urandom_range(17, 31));
            st = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15));
            do_req(a, $urandom, st, rd, er, lat);
        end

        idle(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
